key_sched_seq: RTL and testbench
================================

Name: key_sched_seq

Overview:
- Iterative AES-128 key expansion unit.
- Sits directly upstream of the round datapath: it supplies the key input of one_round for rounds 1..NR-1 and of final_round for round NR.
- Produces one 128-bit round key per handshake, and only one expanded key is held at any time.
- With key_ready tied high it delivers a new key every 2 cycles, matching the round datapath cadence of one round per two clocks.

Parameters:
- NR, 10: index of the last round key emitted. Legal range 1..10. Keys 0..NR are emitted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse that begins an expansion. Honoured only in IDLE.
- key_in  input  128  cipher key, sampled on the start edge. Word w0 = [127:96].
- round_key  output  128  current round key, valid when key_valid=1.
- round_idx  output  4  index of round_key, 0..NR.
- key_valid  output  1  round_key/round_idx are presented.
- key_ready  input  1  consumer accepts the key when key_valid && key_ready.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after key NR is accepted.

Behaviour:
- Reset (async, immediate, also mid-expansion):
  - state=IDLE.
  - round_key=0, round_idx=0.
  - key_valid=0, busy=0, done=0.
  - Any expansion in flight is abandoned with no partial output.
- States:
  - IDLE: on start, round_key<=key_in, round_idx<=0, go to SUB. start while busy is ignored.
  - SUB: exactly 1 cycle, key_valid=0. The S-box sub-module registers SubWord(RotWord(w3)) of the current round_key.
  - OUT: key_valid=1. round_key and round_idx are held stable until acceptance.
    - On accept with round_idx<NR: compute the next key, register it, round_idx++, go to SUB.
    - On accept with round_idx==NR: go to IDLE and done<=1 for one cycle.
- Next-key arithmetic, with t = sbox_q ^ {rcon[round_idx+1],24'h0}:
  - n0 = w0 ^ t
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
  - All XORs are 32-bit; no carries.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Index 0 is unused.
- S-box input is RotWord(w3) = {w3[23:0], w3[31:24]}. The S-box output is used only in OUT, when it has had one full cycle after round_key updated.
- Latency: start sampled at edge E0 → key0 valid in cycle E0+2. With key_ready=1, key k is valid in cycle 2+2k; key 10 is in cycle 22 and done pulses in cycle 23.
- Back-pressure:
  - key_ready low in OUT stalls indefinitely with outputs frozen.
  - No key is skipped or duplicated.
- busy rises in the cycle after start and falls in the same cycle that done pulses.
- start asserted together with done (state already IDLE) is accepted in that cycle.
- round_key retains its last value in IDLE and is don't-care there.

Decomposition:
- Shared package aes_pkg holds:
  - NR_MAX=10
  - the rcon byte table
  - the state enum {IDLE, SUB, OUT}
  - the 32-bit word type
- One sub-module: instance the existing registered 32-bit S-box S4, which has 1-cycle latency and the same contract used in the final round. Do not write a new S-box.
- The FSM, key register and XOR chain stay in key_sched_seq.

Test Plan:
- FIPS-197 App. A: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 → key0=key_in in cycle 2; key1=a0fafe1788542cb123a339392a6c7605 in cycle 4; key10=d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 22; done in cycle 23; busy low from cycle 23.
- key_in=000102030405060708090a0b0c0d0e0f → key1=d6aa74fdd2af72fadaa678f1d6ab76fe; key10=13111d7fe3944a17f307a78b4d2b30c5.
- Back-pressure: drop key_ready for 5 cycles while idx=3 is valid → round_key/round_idx stable throughout; idx=4 appears exactly 2 cycles after ready returns high; final keys match the App. A values.
- start pulsed during OUT at idx=5 → ignored; the sequence completes unchanged with exactly one done pulse.
- Assert rst at idx=6 mid-SUB → all outputs 0 immediately, without waiting for a clock edge. A new start then yields the correct key0..key10.
- NR=1: App. A key → keys 0 and 1 only, then done in cycle 5.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and its S-box.
//   NR_MAX  : largest legal last-round index for AES-128
//   word_t  : 32-bit key-schedule word
//   state_t : key schedule sequencer states
//   RCON    : round constant bytes, index 1..10 used, remainder zero
//   sbox()  : forward AES S-box lookup, rot_word() : byte rotate left
package aes_pkg;

  localparam int unsigned NR_MAX = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    OUT
  } state_t;

  // Padded to 16 entries so any 4-bit index stays in range.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset 8*(255-b); ~b equals 255-b for 8 bits.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_sched_seq_if.sv
// Handshake bundle between the key schedule and its consumer.
//   start/key_in      : launch an expansion with a 128-bit cipher key
//   round_key/idx     : presented key and its round index
//   key_valid/ready   : key transfer handshake
//   busy/done         : expansion in progress / one-cycle completion pulse
interface key_sched_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/key_sched_seq_s4.sv
// Registered 32-bit S-box (four parallel byte lookups, 1-cycle latency).
//   clk, rst : clock, asynchronous active-high reset
//   i_word   : word to substitute
//   o_word   : SubWord(i_word), registered
module aes_s4
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t i_word,
  output word_t o_word
);

  word_t r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_word[8*i +: 8] <= sbox(i_word[8*i +: 8]);
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/key_sched_seq.sv
// Iterative AES-128 key expansion: emits round keys 0..NR, one per
// valid/ready handshake, holding only the current key.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : key_sched_seq_if slave (start/key_in in, keys + status out)
//   NR       : index of the last round key emitted (1..10)
module key_sched_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input logic            clk,
  input logic            rst,
  key_sched_seq_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'((NR > NR_MAX) ? NR_MAX : NR);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_round_key;
  logic [3:0]   r_round_idx;
  logic         r_done;

  word_t        w_rot;
  word_t        w_sbox_q;
  word_t        w_t;
  word_t        w_n0, w_n1, w_n2, w_n3;
  logic [3:0]   w_rcon_idx;
  logic         w_accept;
  logic         w_last;

  // S-box sees RotWord(w3) continuously; its output is only consumed in OUT,
  // by which time it has had the full SUB cycle to settle on the current key.
  assign w_rot = rot_word(r_round_key[31:0]);

  aes_s4 u_s4 (
    .clk    (clk),
    .rst    (rst),
    .i_word (w_rot),
    .o_word (w_sbox_q)
  );

  assign w_accept   = (r_state == OUT) && bus.key_ready;
  assign w_last     = (r_round_idx == LAST_IDX);
  assign w_rcon_idx = r_round_idx + 4'd1;

  assign w_t  = w_sbox_q ^ {RCON[w_rcon_idx], 24'h0};
  assign w_n0 = r_round_key[127:96] ^ w_t;
  assign w_n1 = r_round_key[95:64]  ^ w_n0;
  assign w_n2 = r_round_key[63:32]  ^ w_n1;
  assign w_n3 = r_round_key[31:0]   ^ w_n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SUB;
      SUB:     w_state_nxt = OUT;
      OUT:     if (w_accept) w_state_nxt = w_last ? IDLE : SUB;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_key <= '0;
      r_round_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == IDLE) && bus.start) begin
        r_round_key <= bus.key_in;
        r_round_idx <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_round_key <= {w_n0, w_n1, w_n2, w_n3};
          r_round_idx <= r_round_idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    bus.key_valid = (r_state == OUT);
    bus.busy      = (r_state != IDLE);
    bus.done      = r_done;
    bus.round_key = r_round_key;
    bus.round_idx = r_round_idx;
  end

endmodule

// File: tb/tb_key_sched_seq.sv
module tb_key_sched_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  key_sched_seq_if bus0 ();
  key_sched_seq_if bus1 ();

  key_sched_seq #(.NR(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  key_sched_seq #(.NR(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    int           cyc;
  } exp_t;

  typedef logic [127:0] ks_t [0:10];

  exp_t       q[$];
  logic [7:0] sb [0:255];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: GF(2^8) arithmetic and the textbook word-wise expansion.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] x, inv, r, s;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      end
      s = inv ^ 8'h63;
      r = inv;
      for (int j = 0; j < 4; j++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[v] = s;
    end
  endtask

  function automatic void expand(input logic [127:0] k, output ks_t ks);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Monitor / scoreboard for the NR=10 instance.
  logic         seen = 1'b0;
  logic [127:0] hkey;
  logic [3:0]   hidx;
  int           exp_done = -1;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      seen     = 1'b0;
      exp_done = -1;
    end else begin
      if (bus0.done || cyc == exp_done) begin
        chk("done_pulse", bus0.done, cyc == exp_done);
        if (bus0.done) chk("busy_at_done", bus0.busy, 0);
      end
      if (bus0.key_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key actual idx=%0d key=%h required none", bus0.round_idx, bus0.round_key);
            hidx = bus0.round_idx;
          end else begin
            e = q.pop_front();
            chk("round_key", bus0.round_key, e.key);
            chk("round_idx", bus0.round_idx, e.idx);
            if (e.cyc >= 0) chk("key_cycle", cyc, e.cyc);
            hidx = e.idx;
          end
          seen = 1'b1;
          hkey = bus0.round_key;
        end else begin
          chk("hold_key", bus0.round_key, hkey);
          chk("hold_idx", bus0.round_idx, hidx);
        end
        if (bus0.key_ready) begin
          seen = 1'b0;
          if (hidx == 4'd10) exp_done = cyc + 1;
        end
      end
    end
  end

  // Launches one expansion from the current (mid-cycle, IDLE) point and
  // drives key_ready until done, optionally stalling, pulsing start, or resetting.
  task automatic run_seq(input logic [127:0] key, input bit rnd, input int sidx, input int slen,
                         input int pidx, input int ridx, input bit kat_a, input bit kat_b);
    ks_t ks;
    int  cs, shift;
    expand(key, ks);
    if (kat_a) begin ks[1] = KEY_A1; ks[10] = KEY_A10; end
    if (kat_b) begin ks[1] = KEY_B1; ks[10] = KEY_B10; end
    bus0.start  = 1'b1;
    bus0.key_in = key;
    cs = cyc;
    for (int k = 0; k < 11; k++) begin
      shift = (sidx >= 0 && k > sidx) ? slen : 0;
      q.push_back('{key: ks[k], idx: 4'(k), cyc: rnd ? -1 : cs + 2 + 2*k + shift});
    end
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      bus0.start = (pidx >= 0 && cyc == cs + 2 + 2*pidx);
      if (bus0.start) bus0.key_in = ~key;
      if (cyc == cs + 1) chk("busy_after_start", bus0.busy, 1);
      if (rnd) bus0.key_ready = ($urandom_range(0, 9) < 7);
      else bus0.key_ready = !(sidx >= 0 && cyc >= cs + 2 + 2*sidx && cyc < cs + 2 + 2*sidx + slen);
      if (ridx >= 0 && cyc == cs + 1 + 2*ridx) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", bus0.key_valid, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_key", bus0.round_key, 0);
        chk("rst_idx", bus0.round_idx, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (bus0.done) begin
        if (!rnd) chk("done_cycle", cyc, cs + 23 + ((sidx >= 0) ? slen : 0));
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL seq_timeout actual no done required done within 400 cycles");
  endtask

  initial begin
    bus0.start = 1'b0; bus0.key_in = '0; bus0.key_ready = 1'b1;
    bus1.start = 1'b0; bus1.key_in = '0; bus1.key_ready = 1'b1;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bus0.key_valid, 0);
    chk("reset_busy", bus0.busy, 0);
    chk("reset_done", bus0.done, 0);
    chk("reset_key", bus0.round_key, 0);
    chk("reset_idx", bus0.round_idx, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // NR=1 instance: keys 0 and 1, done in cycle 5.
    bus1.start  = 1'b1;
    bus1.key_in = KEY_A;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("nr1_valid", bus1.key_valid, (i == 2 || i == 4));
      chk("nr1_done", bus1.done, (i == 5));
      if (i == 2) begin chk("nr1_key0", bus1.round_key, KEY_A); chk("nr1_idx0", bus1.round_idx, 0); end
      if (i == 4) begin chk("nr1_key1", bus1.round_key, KEY_A1); chk("nr1_idx1", bus1.round_idx, 1); end
      if (i == 5) chk("nr1_busy_at_done", bus1.busy, 0);
    end
    @(posedge clk);
    #1;

    run_seq(KEY_A, 0, -1, 0, -1, -1, 1, 0);
    run_seq(KEY_B, 0, -1, 0, -1, -1, 0, 1);
    run_seq(KEY_A, 0,  3, 5, -1, -1, 1, 0);
    run_seq(KEY_A, 0, -1, 0,  5, -1, 1, 0);
    run_seq(KEY_B, 0, -1, 0, -1,  6, 0, 0);
    run_seq(KEY_A, 0, -1, 0, -1, -1, 1, 0);
    for (int r = 0; r < 4; r++) begin
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1, -1, 0, -1, -1, 0, 0);
    end

    bus0.key_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
